mux8_rr_arbiter: RTL and testbench



---
 rtl/mux8_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
//   Round-robin arbiter that owns the select of a shared 8:1 one-bit mux.
//   An owner keeps the grant until it releases (rel, or by dropping its
//   request). Every hand-over passes through a one-cycle GAP with gnt = 0,
//   so the mux select never moves while a grant is active.
//
//   Optional feature: define MUX8_ARB_TIMEOUT_EN to build a hold counter
//   that revokes a grant held for HOLD_MAX cycles and pulses timeout_o.
//
// Parameters
//   HOLD_MAX  : max BUSY cycles per grant (2..256), timeout build only
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req[7:0]  : request per requester, bit k <-> mux input k
//   rel       : release strobe from the current owner (BUSY only)
//   gnt[7:0]  : registered one-hot grant, zero when no owner
//   sel[2:0]  : registered mux select, index of current/last owner
//   gnt_vld   : registered OR of gnt
//   timeout_o : one-cycle pulse when a grant is forcibly revoked
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_vld,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state, state_d;
    logic [2:0] ptr, ptr_d;
    logic [7:0] gnt_d;
    logic [2:0] sel_d;
    logic       vld_d;
    logic       to_d;

    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    logic       release_w;
    logic       limit;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold
            $error("mux8_rr_arbiter: HOLD_MAX out of range 2..256");
        end
    endgenerate

    // Rotating priority search starting at ptr. Walking offsets from high
    // to low lets the smallest offset (highest priority) win last.
    always_comb begin
        win   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // A dropped owner request is an implicit release; both together are
    // still just one release.
    assign release_w = rel | ~req[sel];

`ifdef MUX8_ARB_TIMEOUT_EN
    logic [7:0] cnt, cnt_d;

    // Counter is zero outside BUSY, so it is already clear on BUSY entry
    // and reads k-1 during the k-th BUSY cycle.
    always_comb begin
        cnt_d = 8'd0;
        if (state == BUSY)
            cnt_d = cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 8'd0;
        else        cnt <= cnt_d;
    end

    assign limit = (cnt == 8'(HOLD_MAX - 1));
`else
    assign limit = 1'b0;
`endif

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        sel_d   = sel;
        vld_d   = gnt_vld;
        ptr_d   = ptr;
        to_d    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    gnt_d   = 8'b1 << win;
                    sel_d   = win;
                    vld_d   = 1'b1;
                    ptr_d   = win + 3'd1;
                end
            end
            BUSY: begin
                if (release_w || limit) begin
                    state_d = GAP;
                    gnt_d   = 8'h00;
                    vld_d   = 1'b0;
                    // a real release on the limit cycle wins over timeout
                    to_d    = limit & ~release_w;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt       <= 8'h00;
            sel       <= 3'd0;
            gnt_vld   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            gnt_vld   <= vld_d;
            timeout_o <= to_d;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//   Directed self-checking bench for mux8_rr_arbiter (HOLD_MAX = 4).
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   that same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_vld;
    logic       timeout_o;

    int passed = 0;
    int total  = 0;

    mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_vld   (gnt_vld),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // full output check: gnt, sel, gnt_vld, timeout_o and one-hot invariant
    task automatic chk_all(input string tag, input logic [7:0] eg, input logic [2:0] es,
                           input logic ev, input logic et);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".sel"}, 32'(sel), 32'(es));
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(ev));
        chk({tag, ".to"},  32'(timeout_o), 32'(et));
        chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        tick(); tick();
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("idle0", 8'h00, 3'd0, 1'b0, 1'b0);

        // rotation: all request, each owner releases one cycle after grant
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk_all($sformatf("rot%0d.busy", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0);
            rel = 1'b1;
            tick();
            chk_all($sformatf("rot%0d.gap", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
            rel = 1'b0;
            tick();
            chk_all($sformatf("rot%0d.idle", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
        end
        req = 8'h00;
        tick();
        chk_all("rot.end", 8'h00, 3'd0, 1'b0, 1'b0);

        // single request, release, re-grant while still held
        req = 8'h10;
        tick();
        chk_all("single.g1", 8'h10, 3'd4, 1'b1, 1'b0);
        rel = 1'b1;
        tick();
        chk_all("single.gap", 8'h00, 3'd4, 1'b0, 1'b0);
        rel = 1'b0;
        tick();
        chk_all("single.idle", 8'h00, 3'd4, 1'b0, 1'b0);
        tick();
        chk_all("single.g2", 8'h10, 3'd4, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_all("single.drop", 8'h00, 3'd4, 1'b0, 1'b0);
        tick();

        // wrap: grant 6 (ptr -> 7), then 0x41 must go to 0
        req = 8'h40;
        tick();
        chk_all("wrap.g6", 8'h40, 3'd6, 1'b1, 1'b0);
        req = 8'h41;
        rel = 1'b1;
        tick();
        chk_all("wrap.gap", 8'h00, 3'd6, 1'b0, 1'b0);
        rel = 1'b0;
        tick();
        tick();
        chk_all("wrap.g0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        tick();

        // rel in IDLE is ignored
        rel = 1'b1;
        tick();
        chk_all("idlerel", 8'h00, 3'd0, 1'b0, 1'b0);
        rel = 1'b0;

        // implicit release: ptr = 1, owner 3 drops its request
        req = 8'h88;
        tick();
        chk_all("impl.g3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h80;
        tick();
        chk_all("impl.gap", 8'h00, 3'd3, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("impl.g7", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        tick();

        // hold / timeout: ptr = 0, owner 2 never releases
        req = 8'h04;
        tick();
        chk_all("hold.c1", 8'h04, 3'd2, 1'b1, 1'b0);
`ifdef MUX8_ARB_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk_all("to.c4", 8'h04, 3'd2, 1'b1, 1'b0);
        tick();
        chk_all("to.pulse", 8'h00, 3'd2, 1'b0, 1'b1);
        tick();
        chk_all("to.idle", 8'h00, 3'd2, 1'b0, 1'b0);
        tick();
        chk_all("to.regrant", 8'h04, 3'd2, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        rel = 1'b1;
        tick();
        chk_all("to.relwins", 8'h00, 3'd2, 1'b0, 1'b0);
        rel = 1'b0;
`else
        for (int c = 0; c < 110; c++) tick();
        chk_all("hold.c111", 8'h04, 3'd2, 1'b1, 1'b0);
        rel = 1'b1;
        tick();
        chk_all("hold.rel", 8'h00, 3'd2, 1'b0, 1'b0);
        rel = 1'b0;
`endif
        req = 8'h00;
        tick();
        tick();

        // asynchronous reset mid-BUSY, checked before the next edge
        req = 8'h02;
        tick();
        chk_all("arst.g1", 8'h02, 3'd1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("arst", 8'h00, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
